ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the core to the attached keyboard. It drives the PS/2 clock and data lines through open-drain enables, alongside the existing PS/2 keyboard receiver. The block runs in the 6.5 MHz video clock domain. While the block is busy, the receiver ignores the lines; `busy` is used for that gating.

---
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_host_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Core-side command handshake for the PS/2 host transmitter: one byte per request,
// with busy gating and single-cycle done/error completion pulses.
interface ps2_host_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output din, output din_valid, input busy, input done, input error);
  modport slave  (input din, input din_valid, output busy, output done, output error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard through open-drain enables.
// Optional watchdog: define PS2TX_TIMEOUT_EN to abort a stalled transfer after TIMEOUT_CYCLES.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 700,
  parameter int TIMEOUT_CYCLES = 97500
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2clk_in,
  input  logic          ps2data_in,
  output logic          ps2clk_oe,
  output logic          ps2data_oe,
  ps2_host_tx_if.slave  cmd
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, RECOVER} state_t;

  state_t           state, state_nx;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       frame;
  logic             data_drv;
  logic             done_q, error_q, done_nx, error_nx;
  logic             accept;

  logic       ps2clk_p0, ps2clk_p1, ps2dat_p0, ps2dat_p1;
  logic [2:0] clk_hist, dat_hist;
  logic       clk_filt, dat_filt, clk_filt_d;
  logic       fall;

  // Frame bit for a given count: 0-7 data LSB first, 8 parity, 9 and above stop.
  function automatic logic tx_bit(input logic [8:0] frm, input logic [3:0] idx);
    if (idx <= 4'd8) return frm[idx];
    return 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronizers, then a history of the last samples for the filter
  always_ff @(posedge clk) begin
    ps2clk_p0 <= ps2clk_in;
    ps2clk_p1 <= ps2clk_p0;
    ps2dat_p0 <= ps2data_in;
    ps2dat_p1 <= ps2dat_p0;
    clk_hist  <= {clk_hist[1:0], ps2clk_p1};
    dat_hist  <= {dat_hist[1:0], ps2dat_p1};
  end

  // Filtered levels move only after four equal consecutive synchronized samples
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      dat_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      if (&{clk_hist, ps2clk_p1})       clk_filt <= 1'b1;
      else if (~|{clk_hist, ps2clk_p1}) clk_filt <= 1'b0;
      if (&{dat_hist, ps2dat_p1})       dat_filt <= 1'b1;
      else if (~|{dat_hist, ps2dat_p1}) dat_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  assign fall   = clk_filt_d & ~clk_filt;
  assign accept = (state == IDLE) && cmd.din_valid && !done_q && !error_q;

`ifdef PS2TX_TIMEOUT_EN
  localparam logic [16:0] WD_LAST = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset || state == INHIBIT || state_nx == IDLE) wd_cnt <= '0;
    else if (state inside {REQ, SHIFT, ACK, WAIT_IDLE}) wd_cnt <= wd_cnt + 17'd1;
  end
`endif

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    error_nx = 1'b0;
    case (state)
      IDLE:      if (accept) state_nx = INHIBIT;
      INHIBIT:   if (inh_cnt == INH_LAST) state_nx = REQ;
      REQ:       state_nx = SHIFT;
      SHIFT:     if (fall && bit_cnt == 4'd9) state_nx = ACK;
      ACK:       if (fall) state_nx = dat_filt ? RECOVER : WAIT_IDLE;
      WAIT_IDLE: if (clk_filt && dat_filt) begin
                   state_nx = IDLE;
                   done_nx  = 1'b1;
                 end
      // A missing ACK is reported once the lines are idle, so busy drops with the pulse
      RECOVER:   if (clk_filt && dat_filt) begin
                   state_nx = IDLE;
                   error_nx = 1'b1;
                 end
      default:   state_nx = IDLE;
    endcase
`ifdef PS2TX_TIMEOUT_EN
    if ((state inside {REQ, SHIFT, ACK, WAIT_IDLE}) && wd_cnt == WD_LAST) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
      error_nx = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      inh_cnt  <= '0;
      bit_cnt  <= '0;
      data_drv <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      done_q  <= done_nx;
      error_q <= error_nx;
      inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
      if (state_nx == REQ) begin
        data_drv <= 1'b1;
        bit_cnt  <= '0;
      end else if (state == SHIFT && fall) begin
        data_drv <= ~tx_bit(frame, bit_cnt);
        bit_cnt  <= bit_cnt + 4'd1;
      end
      if (state_nx == IDLE || state_nx == RECOVER) data_drv <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) frame <= {~^cmd.din, cmd.din};
  end

  assign ps2clk_oe  = (state == INHIBIT);
  assign ps2data_oe = data_drv;
  assign cmd.busy   = (state != IDLE);
  assign cmd.done   = done_q;
  assign cmd.error  = error_q;

endmodule
